// File: rtl/game_stage_fsm.sv
// Game stage controller: start screen, battle, win and lose screens.
// Sequences the stages from Enter/Esc key presses, player-death flags and
// VGA frame ticks. Every output comes straight from a flop.
module game_stage_fsm #(
    parameter logic [7:0]  ENTER_KEY  = 8'h28,
    parameter logic [7:0]  ESC_KEY    = 8'h29,
    parameter int unsigned START_HOLD = 60,
    parameter int unsigned END_HOLD   = 120
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       frame_clk,
    input  logic [7:0] keycode,
    input  logic       p1_dead,
    input  logic       p2_dead,
    output logic       start_l,
    output logic       battle_l,
    output logic       win_l,
    output logic       lose_l,
    output logic       round_reset
);

    localparam logic [7:0] StartHoldC = 8'(START_HOLD);
    localparam logic [7:0] EndHoldC   = 8'(END_HOLD);

    typedef enum logic [1:0] {StStart, StBattle, StWin, StLose} state_e;

    state_e     state_q, state_d;
    logic [7:0] hold_cnt_q, hold_cnt_d;
    logic       fc_sync1_q, fc_sync1_d;
    logic       fc_sync2_q, fc_sync2_d;
    logic       fc_prev_q, fc_prev_d;
    logic [1:0] fc_fill_q, fc_fill_d;
    logic       fc_armed_q, fc_armed_d;
    logic       enter_prev_q, enter_prev_d;
    logic       start_l_q, start_l_d;
    logic       battle_l_q, battle_l_d;
    logic       win_l_q, win_l_d;
    logic       lose_l_q, lose_l_d;
    logic       round_reset_q, round_reset_d;

    logic       frame_tick;
    logic       enter_match;
    logic       enter_press;
    logic       esc_match;
    logic [7:0] hold_lim;

    // Frame sync chain, edge detect and key-press qualification.
    // fc_fill counts the edges until the sync chain holds a real sample;
    // the edge detector only arms once it has seen frame_clk low, so a
    // frame_clk held high through reset does not produce a tick.
    always_comb begin
        fc_sync1_d   = frame_clk;
        fc_sync2_d   = fc_sync1_q;
        fc_prev_d    = fc_sync2_q;
        fc_fill_d    = (fc_fill_q == 2'd2) ? fc_fill_q : fc_fill_q + 2'd1;
        fc_armed_d   = fc_armed_q | ((fc_fill_q == 2'd2) & ~fc_sync2_q);
        frame_tick   = fc_sync2_q & ~fc_prev_q & fc_armed_q;
        enter_match  = (keycode == ENTER_KEY);
        enter_prev_d = enter_match;
        enter_press  = enter_match & ~enter_prev_q;
        esc_match    = (keycode == ESC_KEY);
    end

    // Next-state logic; Esc outside START overrides everything else.
    always_comb begin
        state_d = state_q;
        if (state_q != StStart && esc_match) begin
            state_d = StStart;
        end else begin
            unique case (state_q)
                StStart: begin
                    if (hold_cnt_q >= StartHoldC && enter_press) state_d = StBattle;
                end
                StBattle: begin
                    if (p1_dead)      state_d = StLose;
                    else if (p2_dead) state_d = StWin;
                end
                StWin, StLose: begin
                    if (hold_cnt_q >= EndHoldC && enter_press) state_d = StStart;
                end
                default: state_d = StStart;
            endcase
        end
    end

    // Frame hold counter: clears on any stage change, saturates at the stage limit.
    always_comb begin
        unique case (state_q)
            StStart:  hold_lim = StartHoldC;
            StBattle: hold_lim = 8'd0;
            default:  hold_lim = EndHoldC;
        endcase
        hold_cnt_d = hold_cnt_q;
        if (state_d != state_q) begin
            hold_cnt_d = 8'd0;
        end else if (frame_tick && hold_cnt_q < hold_lim) begin
            hold_cnt_d = hold_cnt_q + 8'd1;
        end
    end

    // Registered stage outputs, decoded from the next state.
    always_comb begin
        start_l_d     = (state_d == StStart);
        battle_l_d    = (state_d == StBattle);
        win_l_d       = (state_d == StWin);
        lose_l_d      = (state_d == StLose);
        round_reset_d = (state_q == StStart) && (state_d == StBattle);
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q       <= StStart;
            hold_cnt_q    <= 8'd0;
            fc_sync1_q    <= 1'b0;
            fc_sync2_q    <= 1'b0;
            fc_prev_q     <= 1'b0;
            fc_fill_q     <= 2'd0;
            fc_armed_q    <= 1'b0;
            enter_prev_q  <= 1'b1;
            start_l_q     <= 1'b1;
            battle_l_q    <= 1'b0;
            win_l_q       <= 1'b0;
            lose_l_q      <= 1'b0;
            round_reset_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            hold_cnt_q    <= hold_cnt_d;
            fc_sync1_q    <= fc_sync1_d;
            fc_sync2_q    <= fc_sync2_d;
            fc_prev_q     <= fc_prev_d;
            fc_fill_q     <= fc_fill_d;
            fc_armed_q    <= fc_armed_d;
            enter_prev_q  <= enter_prev_d;
            start_l_q     <= start_l_d;
            battle_l_q    <= battle_l_d;
            win_l_q       <= win_l_d;
            lose_l_q      <= lose_l_d;
            round_reset_q <= round_reset_d;
        end
    end

    assign start_l     = start_l_q;
    assign battle_l    = battle_l_q;
    assign win_l       = win_l_q;
    assign lose_l      = lose_l_q;
    assign round_reset = round_reset_q;

endmodule

// File: tb/tb_game_stage_fsm.sv
// Directed bench for game_stage_fsm with a scoreboard of expected outputs.
module tb_game_stage_fsm;

    logic       Clk = 1'b0;
    logic       Reset_n;
    logic       frame_clk;
    logic [7:0] keycode;
    logic       p1_dead;
    logic       p2_dead;
    logic       start_l, battle_l, win_l, lose_l, round_reset;

    int total = 0;
    int bad   = 0;

    // Output vector order: {start_l, battle_l, win_l, lose_l, round_reset}
    localparam logic [4:0] OS  = 5'b10000;
    localparam logic [4:0] OB  = 5'b01000;
    localparam logic [4:0] OBR = 5'b01001;
    localparam logic [4:0] OW  = 5'b00100;
    localparam logic [4:0] OL  = 5'b00010;

    typedef struct {
        string      tag;
        logic [4:0] exp;
    } exp_t;

    exp_t sb_q[$];

    game_stage_fsm dut (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .frame_clk   (frame_clk),
        .keycode     (keycode),
        .p1_dead     (p1_dead),
        .p2_dead     (p2_dead),
        .start_l     (start_l),
        .battle_l    (battle_l),
        .win_l       (win_l),
        .lose_l      (lose_l),
        .round_reset (round_reset)
    );

    always #10 Clk = ~Clk;

    function automatic logic [4:0] outs();
        return {start_l, battle_l, win_l, lose_l, round_reset};
    endfunction

    // Exactly one stage output high, checked every cycle.
    always @(negedge Clk) begin
        total++;
        assert ($countones({start_l, battle_l, win_l, lose_l}) == 1)
        else begin
            bad++;
            $error("FAIL onehot: got %b want exactly one of start/battle/win/lose",
                   {start_l, battle_l, win_l, lose_l});
        end
    end

    task automatic clk1();
        @(posedge Clk);
        #2;
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            frame_clk = 1'b1;
            repeat (3) clk1();
            frame_clk = 1'b0;
            repeat (3) clk1();
        end
    endtask

    task automatic check_sb();
        exp_t       x;
        logic [4:0] o;
        total++;
        if (sb_q.size() == 0) begin
            bad++;
            $error("FAIL scoreboard_empty: got no entry want one entry");
        end else begin
            x = sb_q.pop_front();
            o = outs();
            assert (o === x.exp)
            else begin
                bad++;
                $error("FAIL %s: got %b want %b", x.tag, o, x.exp);
            end
        end
    endtask

    // Drive one cycle of inputs, queue the outputs expected one Clk later.
    task automatic step(input logic [7:0] kc, input logic d1, input logic d2,
                        input string tag, input logic [4:0] e);
        exp_t x;
        keycode = kc;
        p1_dead = d1;
        p2_dead = d2;
        x.tag   = tag;
        x.exp   = e;
        sb_q.push_back(x);
        clk1();
        check_sb();
    endtask

    task automatic check_now(input string tag, input logic [4:0] e);
        logic [4:0] o;
        o = outs();
        total++;
        assert (o === e)
        else begin
            bad++;
            $error("FAIL %s: got %b want %b", tag, o, e);
        end
    endtask

    task automatic check_hold(input string tag, input logic [7:0] e);
        total++;
        assert (dut.hold_cnt_q === e)
        else begin
            bad++;
            $error("FAIL %s: got hold_cnt=%0d want %0d", tag, dut.hold_cnt_q, e);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish want finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        Reset_n   = 1'b0;
        frame_clk = 1'b0;
        keycode   = 8'h00;
        p1_dead   = 1'b0;
        p2_dead   = 1'b0;
        repeat (3) clk1();
        check_now("reset_outputs", OS);
        check_hold("reset_hold", 8'd0);
        Reset_n = 1'b1;
        clk1();

        // Early Enter discarded, held Enter does not retrigger.
        frames(10);
        step(8'h28, 1'b0, 1'b0, "enter_early", OS);
        frames(50);
        check_hold("hold_60", 8'd60);
        step(8'h28, 1'b0, 1'b0, "enter_held_60", OS);
        step(8'h00, 1'b0, 1'b0, "enter_released", OS);
        step(8'h28, 1'b0, 1'b0, "enter_new_press", OBR);
        step(8'h00, 1'b0, 1'b0, "round_reset_one_clk", OB);

        // Simultaneous deaths -> lose; deaths/early Enter ignored in LOSE; Esc.
        step(8'h00, 1'b1, 1'b1, "both_dead_lose", OL);
        step(8'h00, 1'b0, 1'b1, "p2_ignored_lose", OL);
        step(8'h28, 1'b0, 1'b0, "enter_lose_early", OL);
        step(8'h29, 1'b0, 1'b0, "esc_from_lose", OS);
        check_hold("hold_clr_esc", 8'd0);
        step(8'h29, 1'b0, 1'b0, "esc_in_start", OS);
        step(8'h00, 1'b0, 1'b0, "start_idle", OS);

        // 60 frames then a one-Clk Enter pulse.
        frames(60);
        step(8'h28, 1'b0, 1'b0, "enter_after_60", OBR);
        step(8'h00, 1'b0, 1'b0, "battle_steady", OB);
        step(8'h00, 1'b0, 1'b1, "p2_dead_win", OW);
        step(8'h00, 1'b1, 1'b0, "p1_ignored_win", OW);
        step(8'h00, 1'b0, 1'b0, "win_steady", OW);

        // Win screen threshold at 119 versus 120 frames.
        frames(119);
        step(8'h28, 1'b0, 1'b0, "enter_at_119", OW);
        step(8'h00, 1'b0, 1'b0, "win_released", OW);
        frames(1);
        check_hold("hold_120", 8'd120);
        step(8'h28, 1'b0, 1'b0, "enter_at_120", OS);
        check_hold("hold_clr_win", 8'd0);
        step(8'h00, 1'b0, 1'b0, "start_after_win", OS);

        // Esc from battle, no round_reset.
        frames(60);
        step(8'h28, 1'b0, 1'b0, "enter_battle2", OBR);
        step(8'h00, 1'b0, 1'b0, "battle2_steady", OB);
        step(8'h29, 1'b0, 1'b0, "esc_from_battle", OS);
        step(8'h00, 1'b0, 1'b0, "start_after_esc", OS);

        // Into LOSE via p1 only, then asynchronous reset mid-stage.
        frames(60);
        step(8'h28, 1'b0, 1'b0, "enter_battle3", OBR);
        step(8'h00, 1'b0, 1'b0, "battle3_steady", OB);
        step(8'h00, 1'b1, 1'b0, "p1_dead_lose", OL);
        step(8'h00, 1'b0, 1'b0, "lose_steady", OL);
        #3;
        Reset_n = 1'b0;
        #1;
        check_now("async_reset_lose", OS);

        // frame_clk and Enter held high through reset release.
        frame_clk = 1'b1;
        keycode   = 8'h28;
        repeat (2) clk1();
        Reset_n = 1'b1;
        repeat (6) clk1();
        check_hold("no_tick_after_reset", 8'd0);
        frame_clk = 1'b0;
        repeat (3) clk1();
        frames(65);
        check_hold("hold_saturates_60", 8'd60);
        step(8'h28, 1'b0, 1'b0, "enter_held_thru_reset", OS);
        step(8'h00, 1'b0, 1'b0, "enter_released2", OS);
        step(8'h28, 1'b0, 1'b0, "enter_after_release", OBR);
        step(8'h00, 1'b0, 1'b0, "battle4_steady", OB);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/game_stage_fsm.md
GAME_STAGE_FSM -- requirements
Module: game_stage_fsm

Interface
REQ-001 Parameter ENTER_KEY, default 8'h28, USB keycode that advances the stage.
REQ-002 Parameter ESC_KEY, default 8'h29, USB keycode that aborts to the start screen.
REQ-003 Parameter START_HOLD, default 60, frames the start screen SHALL show before Enter is accepted.
REQ-004 Parameter END_HOLD, default 120, frames the win/lose screen SHALL show before Enter is accepted.
REQ-005 Port Clk  input  1  system clock (50 MHz); all state changes on rising edge.
REQ-006 Port Reset_n  input  1  reset, asynchronous, active-low.
REQ-007 Port frame_clk  input  1  VGA vertical sync, asynchronous to Clk.
REQ-008 Port keycode  input  8  current keyboard keycode; 8'h00 means no key.
REQ-009 Port p1_dead  input  1  player-1 health is zero, level, Clk domain.
REQ-010 Port p2_dead  input  1  player-2 health is zero, level, Clk domain.
REQ-011 Port start_l  output  1  start screen active, drives color_mapper start_l.
REQ-012 Port battle_l  output  1  battle stage active.
REQ-013 Port win_l  output  1  victory screen active.
REQ-014 Port lose_l  output  1  defeat screen active.
REQ-015 Port round_reset  output  1  one-Clk pulse that re-initialises players and projectiles.

Function
REQ-016 The block SHALL synchronise frame_clk through two flops and SHALL produce frame_tick, a one-Clk pulse on each synchronised rising edge.
REQ-017 The block SHALL detect enter_press as keycode==ENTER_KEY this cycle while the registered previous-cycle match is 0.
REQ-018 The block SHALL hold exactly one of start_l/battle_l/win_l/lose_l high at all times. Outputs SHALL be registered and SHALL equal the current state.
REQ-019 The states SHALL be START, BATTLE, WIN, LOSE. Each state SHALL drive its matching output.
REQ-020 hold_cnt (8 bits) SHALL clear on every state change. It SHALL increment on frame_tick and saturate at the current state's hold value; it SHALL never wrap.
REQ-021 START -> BATTLE SHALL occur when hold_cnt>=START_HOLD and enter_press. round_reset SHALL pulse high for the single Clk in which battle_l first goes high.
REQ-022 BATTLE -> LOSE SHALL occur when p1_dead=1, including when p1_dead and p2_dead assert in the same cycle (lose has priority).
REQ-023 BATTLE -> WIN SHALL occur when p2_dead=1 and p1_dead=0.
REQ-024 WIN or LOSE -> START SHALL occur when hold_cnt>=END_HOLD and enter_press.
REQ-025 keycode==ESC_KEY in BATTLE, WIN or LOSE SHALL force START on the next Clk, with priority over all other transitions. ESC in START SHALL have no effect.
REQ-026 The state output SHALL change exactly one Clk after the qualifying condition is sampled.
REQ-027 enter_press occurring while hold_cnt is below threshold SHALL be discarded. A held Enter key SHALL NOT re-trigger until it is released for at least one Clk.
REQ-028 frame_tick and enter_press in the same cycle SHALL use the pre-increment hold_cnt for the threshold compare.
REQ-029 p1_dead/p2_dead SHALL be ignored outside BATTLE.
REQ-030 The block SHALL contain no combinational path from any input to any output.

Reset
REQ-031 While Reset_n=0 the block SHALL hold state START, start_l=1, battle_l=win_l=lose_l=0, round_reset=0, hold_cnt=0, sync/edge flops=0, and the Enter previous-match flop=1. This blocks an Enter held through reset.
REQ-032 Reset assertion mid-stage (any state) SHALL take effect without waiting for Clk. After release, the first frame_tick SHALL NOT occur until a fresh rising frame_clk edge.

Verification
REQ-033 Reset, 60 frame_clk pulses, then pulse keycode=8'h28 for 1 Clk -> start_l=0, battle_l=1 one Clk later; round_reset=1 for exactly that Clk.
REQ-034 In START after 10 frames, press Enter -> stays START. At 60 frames with Enter still held -> no transition. Release then press -> BATTLE.
REQ-035 In BATTLE, assert p1_dead and p2_dead in the same Clk -> lose_l=1, win_l=0. Separate run with p2_dead only -> win_l=1.
REQ-036 In WIN, press Enter at 119 frames -> stays WIN. Press at 120 frames -> start_l=1, hold_cnt=0.
REQ-037 In BATTLE, keycode=8'h29 -> start_l=1 next Clk, round_reset=0. Pulse Reset_n low mid-LOSE -> start_l=1 immediately, without a Clk edge.
REQ-038 Every cycle in every test -> assert that start_l+battle_l+win_l+lose_l==1.
